// File: rtl/udp_seg_display.sv
// udp_seg_display
//   Frames a UDP payload with a per-packet byte counter and captures the first
//   NUM_DIGITS bytes into a shadow buffer. At the last byte of the packet the
//   shadow buffer is committed in one step to the display buffer. The committed
//   digits are then time-multiplexed onto a common-anode seven-segment display.
//
// Ports
//   clk                 system clock (UDP RX interface is synchronous to it)
//   reset               asynchronous, active-high reset
//   app_rx_data_valid   payload byte strobe
//   app_rx_data         payload byte
//   app_rx_data_length  payload length in bytes, sampled on the first byte
//   ascii_mode          0 = hex low-nibble glyphs, 1 = ASCII glyphs
//   blank_lead_zero     1 = suppress leading zero digits
//   dataout             segments, active-low {dp,g,f,e,d,c,b,a}; dp always off
//   en                  digit enables, active-low, one-hot-low
//   pkt_done            one-cycle pulse after each packet commit
//   pkt_count           committed packet count (wraps)
module udp_seg_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  app_rx_data_valid,
    input  logic [7:0]            app_rx_data,
    input  logic [15:0]           app_rx_data_length,
    input  logic                  ascii_mode,
    input  logic                  blank_lead_zero,
    output logic [7:0]            dataout,
    output logic [NUM_DIGITS-1:0] en,
    output logic                  pkt_done,
    output logic [15:0]           pkt_count
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    // Seven-segment pattern for a hex nibble, active-low, dp off.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_seg = 8'hC0;
            4'h1:    hex_seg = 8'hF9;
            4'h2:    hex_seg = 8'hA4;
            4'h3:    hex_seg = 8'hB0;
            4'h4:    hex_seg = 8'h99;
            4'h5:    hex_seg = 8'h92;
            4'h6:    hex_seg = 8'h82;
            4'h7:    hex_seg = 8'hF8;
            4'h8:    hex_seg = 8'h80;
            4'h9:    hex_seg = 8'h90;
            4'hA:    hex_seg = 8'h88;
            4'hB:    hex_seg = 8'h83;
            4'hC:    hex_seg = 8'hC6;
            4'hD:    hex_seg = 8'hA1;
            4'hE:    hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [7:0] b, input logic asc);
        if (!asc)
            decode = hex_seg(b[3:0]);
        else if (b >= 8'h30 && b <= 8'h39)
            decode = hex_seg(b[3:0]);
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            decode = hex_seg(b[3:0] + 4'd9);
        else if (b == 8'h2D)
            decode = 8'hBF;
        else
            decode = 8'hFF;
    endfunction

    // A digit counts as "zero" for blanking when its glyph would be 0.
    function automatic logic is_zero(input logic [7:0] b, input logic asc);
        is_zero = asc ? (b == 8'h30) : (b[3:0] == 4'h0);
    endfunction

    // ---------------- framing / capture ----------------
    logic [15:0]                 cnt;
    logic [15:0]                 len_q;
    logic [NUM_DIGITS-1:0][7:0]  sh_buf;
    logic [NUM_DIGITS-1:0]       sh_mask;
    logic [NUM_DIGITS-1:0][7:0]  disp_buf;
    logic [NUM_DIGITS-1:0]       disp_mask;

    logic                        first_byte;
    logic [15:0]                 len_in;
    logic [15:0]                 cur_len;
    logic                        last_byte;
    logic                        in_range;
    logic [IDX_W-1:0]            slot;
    logic [NUM_DIGITS-1:0][7:0]  sh_buf_n;
    logic [NUM_DIGITS-1:0]       sh_mask_n;

    always_comb begin
        first_byte = (cnt == 16'd0);
        len_in     = (app_rx_data_length == 16'd0) ? 16'd1 : app_rx_data_length;
        // On the first byte the latched length is not yet valid, so use the input.
        cur_len    = first_byte ? len_in : len_q;
        last_byte  = app_rx_data_valid && (cnt == cur_len - 16'd1);
        in_range   = (cnt < 16'(NUM_DIGITS));
        slot       = IDX_W'(NUM_DIGITS - 1) - cnt[IDX_W-1:0];

        // Shadow contents including the current byte; this is what a commit sees.
        sh_buf_n   = sh_buf;
        sh_mask_n  = first_byte ? '0 : sh_mask;
        if (in_range) begin
            sh_buf_n[slot]  = app_rx_data;
            sh_mask_n[slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            len_q     <= '0;
            sh_buf    <= '0;
            sh_mask   <= '0;
            disp_buf  <= '0;
            disp_mask <= '0;
            pkt_done  <= 1'b0;
            pkt_count <= '0;
        end else begin
            pkt_done <= last_byte;
            if (last_byte)
                pkt_count <= pkt_count + 16'd1;
            if (app_rx_data_valid) begin
                sh_buf  <= sh_buf_n;
                sh_mask <= sh_mask_n;
                if (first_byte)
                    len_q <= len_in;
                if (last_byte) begin
                    cnt       <= '0;
                    disp_buf  <= sh_buf_n;
                    disp_mask <= sh_mask_n;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- leading-zero blanking ----------------
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lz_run;
    int unsigned           lz_i;

    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lead_zero;
        lz_i     = 0;
        // Walk from the leftmost digit; the run stops at the first valid
        // non-zero digit or the first unreceived digit.
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            lz_i   = NUM_DIGITS - 1 - j;
            lz_run = lz_run && disp_mask[lz_i] && is_zero(disp_buf[lz_i], ascii_mode);
            lz_blank[lz_i] = lz_run && (lz_i != 0);
        end
    end

    // ---------------- scan ----------------
    logic [DW_W-1:0]  dwell;
    logic [IDX_W-1:0] idx;
    logic [7:0]       glyph;

    always_comb begin
        if (!disp_mask[idx] || lz_blank[idx])
            glyph = 8'hFF;
        else
            glyph = decode(disp_buf[idx], ascii_mode);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell   <= '0;
            idx     <= '0;
            en      <= '1;
            dataout <= 8'hFF;
        end else begin
            if (dwell == DW_W'(DWELL_CYCLES - 1)) begin
                dwell <= '0;
                idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
            en      <= ~(NUM_DIGITS'(1) << idx);
            dataout <= glyph;
        end
    end

endmodule
